// File: rtl/ac_pkg.sv
// Shared encodings and thresholds for the air-conditioning controller and its room plant.
package ac_pkg;

   localparam int TEMP_W = 5;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_COOL  = 2'b01,
      MODE_HEAT  = 2'b10,
      MODE_FAULT = 2'b11
   } mode_e;

   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_COOL  = 2'b01;
   localparam logic [1:0] CMD_HEAT  = 2'b10;
   localparam logic [1:0] CMD_FAULT = 2'b11;

   localparam logic [TEMP_W-1:0] LOWER_TEMP = 5'd18;
   localparam logic [TEMP_W-1:0] MID_TEMP   = 5'd20;
   localparam logic [TEMP_W-1:0] UPPER_TEMP = 5'd22;

   // One degree up or down, computed one bit wider so overflow/underflow clamp instead of wrapping.
   function automatic logic [TEMP_W-1:0] sat_step(input logic [TEMP_W-1:0] t, input logic up);
      logic [TEMP_W:0] sum;
      sum = {1'b0, t} + (up ? 6'd1 : 6'h3F);
      if (sum[TEMP_W]) begin
         sat_step = up ? 5'd31 : 5'd0;
      end else begin
         sat_step = sum[TEMP_W-1:0];
      end
   endfunction

endpackage

// File: rtl/room_temperature_model_step_timer.sv
// Free-running step counter: synchronous clear, hold-at-zero, terminal-count strobe.
module step_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_i,
   input  logic       hold_i,
   input  logic [7:0] period_i,
   output logic       tc_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;
   logic       tc_s;

   // Clear and hold both force zero; terminal count wraps and strobes.
   always_comb begin
      cnt_d = cnt_q;
      tc_s  = 1'b0;
      if (clear_i || hold_i) begin
         cnt_d = 8'd0;
      end else if (cnt_q == (period_i - 8'd1)) begin
         cnt_d = 8'd0;
         tc_s  = 1'b1;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign tc_o = tc_s;

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/room_temperature_model.sv
// Room plant: integrates the {heating, cooling} command into a saturating 5-bit temperature.
module room_temperature_model
   import ac_pkg::*;
#(
   parameter logic [TEMP_W-1:0] INIT_TEMP    = 5'd20,
   parameter logic [TEMP_W-1:0] AMBIENT_TEMP = 5'd15,
   parameter int unsigned       HEAT_PERIOD  = 4,
   parameter int unsigned       COOL_PERIOD  = 4,
   parameter int unsigned       DRIFT_PERIOD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        concat_states,
   output logic [TEMP_W-1:0] temperature,
   output logic              temp_step,
   output logic              fault
);

   if ((HEAT_PERIOD < 1) || (HEAT_PERIOD > 255) ||
       (COOL_PERIOD < 1) || (COOL_PERIOD > 255) ||
       (DRIFT_PERIOD < 1) || (DRIFT_PERIOD > 255)) begin : g_bad_period
      $error("room_temperature_model: step periods must lie in 1..255");
   end

   localparam logic [7:0] HEAT_P  = 8'(HEAT_PERIOD);
   localparam logic [7:0] COOL_P  = 8'(COOL_PERIOD);
   localparam logic [7:0] DRIFT_P = 8'(DRIFT_PERIOD);

   logic [1:0]        prev_cmd_q;
   logic [TEMP_W-1:0] temp_q;
   logic [TEMP_W-1:0] temp_d;
   logic              temp_step_q;
   logic              fault_q;
   mode_e             mode_s;
   logic              cmd_change_s;
   logic              hold_s;
   logic [7:0]        period_s;
   logic              tc_s;

   step_timer u_step_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (cmd_change_s),
      .hold_i   (hold_s),
      .period_i (period_s),
      .tc_o     (tc_s)
   );

   // Mode decode, period select and the next temperature on a step attempt.
   always_comb begin
      mode_s       = mode_e'(prev_cmd_q);
      cmd_change_s = (concat_states != prev_cmd_q);
      hold_s       = (mode_s == MODE_FAULT);
      temp_d       = temp_q;
      case (mode_s)
         MODE_HEAT: period_s = HEAT_P;
         MODE_COOL: period_s = COOL_P;
         MODE_IDLE: period_s = DRIFT_P;
         default:   period_s = 8'd1;
      endcase
      if (tc_s) begin
         case (mode_s)
            MODE_HEAT: temp_d = sat_step(temp_q, 1'b1);
            MODE_COOL: temp_d = sat_step(temp_q, 1'b0);
            MODE_IDLE: begin
               if (temp_q < AMBIENT_TEMP) begin
                  temp_d = sat_step(temp_q, 1'b1);
               end else if (temp_q > AMBIENT_TEMP) begin
                  temp_d = sat_step(temp_q, 1'b0);
               end else begin
                  temp_d = temp_q;
               end
            end
            default:   temp_d = temp_q;
         endcase
      end else begin
         temp_d = temp_q;
      end
   end

   // State and flag registers; the step pulse fires only on a real change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_cmd_q  <= CMD_IDLE;
         temp_q      <= INIT_TEMP;
         temp_step_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         prev_cmd_q  <= concat_states;
         temp_q      <= temp_d;
         temp_step_q <= (temp_d != temp_q);
         fault_q     <= (concat_states == CMD_FAULT);
      end
   end

   assign temperature = temp_q;
   assign temp_step   = temp_step_q;
   assign fault       = fault_q;

endmodule
